// File: rtl/seq_mult_core.sv
// Sequential shift-and-add magnitude multiplier: |A|*|B| over DW cycles, with operand
// sign bits passed through so the downstream stage can restore the product sign.
module seq_mult_core #(
  parameter int unsigned DW   = 8,
  parameter int unsigned DW_2 = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   multiplicand,
  output logic            ready,
  output logic            done,
  output logic [DW_2-1:0] product,
  output logic            multiplier_msb,
  output logic            multiplicand_msb
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic [DW_2-1:0] acc;
  logic [CW-1:0]   cnt;

  // Two's-complement magnitude; the most negative value maps to 2^(DW-1) unsigned.
  assign abs_a = multiplier[DW-1]   ? (~multiplier   + DW'(1)) : multiplier;
  assign abs_b = multiplicand[DW-1] ? (~multiplicand + DW'(1)) : multiplicand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(DW - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a            <= '0;
      mag_b            <= '0;
      acc              <= '0;
      cnt              <= '0;
      product          <= '0;
      multiplier_msb   <= 1'b0;
      multiplicand_msb <= 1'b0;
      ready            <= 1'b1;
      done             <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            multiplier_msb   <= multiplier[DW-1];
            multiplicand_msb <= multiplicand[DW-1];
            mag_a            <= abs_a;
            mag_b            <= abs_b;
            acc              <= '0;
            cnt              <= '0;
          end
        end
        CALC: begin
          if (mag_a[0]) acc <= acc + (DW_2'(mag_b) << cnt);
          mag_a <= mag_a >> 1;
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          product <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_seq_mult_core;

  localparam int unsigned DW   = 8;
  localparam int unsigned DW_2 = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   multiplier = '0;
  logic [DW-1:0]   multiplicand = '0;
  logic            ready;
  logic            done;
  logic [DW_2-1:0] product;
  logic            multiplier_msb;
  logic            multiplicand_msb;

  int n_chk = 0;
  int n_err = 0;

  seq_mult_core #(.DW(DW), .DW_2(DW_2)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .multiplier       (multiplier),
    .multiplicand     (multiplicand),
    .ready            (ready),
    .done             (done),
    .product          (product),
    .multiplier_msb   (multiplier_msb),
    .multiplicand_msb (multiplicand_msb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mag(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  // Transaction-level model: an accepted request yields its result DW+1 edges later.
  bit m_busy   = 1'b0;
  int m_left   = 0;
  int m_pend   = 0;
  bit e_ready  = 1'b1;
  bit e_done   = 1'b0;
  int e_prod   = 0;
  bit e_mmsb   = 1'b0;
  bit e_bmsb   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_left = 0; m_pend = 0;
      e_ready = 1; e_done = 0; e_prod = 0; e_mmsb = 0; e_bmsb = 0;
    end else begin
      e_done = 0;
      if (!m_busy && start) begin
        m_busy  = 1;
        m_left  = DW + 1;
        m_pend  = mag(multiplier) * mag(multiplicand);
        e_mmsb  = multiplier[DW-1];
        e_bmsb  = multiplicand[DW-1];
        e_ready = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          e_ready = 1;
          e_done  = 1;
          e_prod  = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ready", 32'(ready), 32'(e_ready));
    chk("cyc_done", 32'(done), 32'(e_done));
    chk("cyc_product", 32'(product), e_prod);
    chk("cyc_mmsb", 32'(multiplier_msb), 32'(e_mmsb));
    chk("cyc_bmsb", 32'(multiplicand_msb), 32'(e_bmsb));
  end

  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; multiplier = a; multiplicand = b;
    @(posedge clk); #1;
    start = 1'b0; multiplier = DW'($urandom); multiplicand = DW'($urandom);
  endtask

  task automatic wait_done(output bit seen, output int lat);
    seen = 0; lat = 0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int exp_p,
                        input bit exp_m, input bit exp_b, input string nm);
    bit seen;
    int lat;
    start_op(a, b);
    wait_done(seen, lat);
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, lat, 32'd10);
    chk({nm, "_product"}, 32'(product), exp_p);
    chk({nm, "_mmsb"}, 32'(multiplier_msb), 32'(exp_m));
    chk({nm, "_bmsb"}, 32'(multiplicand_msb), 32'(exp_b));
  endtask

  initial begin
    bit seen;
    int lat;
    logic [DW-1:0] corner [5];
    corner[0] = 8'h80; corner[1] = 8'hFF; corner[2] = 8'h00; corner[3] = 8'h7F; corner[4] = 8'h01;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_msbs", {30'd0, multiplier_msb, multiplicand_msb}, 32'd0);
    rst = 1'b1;

    run_op(8'd3, 8'd5, 15, 1'b0, 1'b0, "t1");
    run_op(8'hFD, 8'd5, 15, 1'b1, 1'b0, "t2");
    run_op(8'h80, 8'h80, 32'h4000, 1'b1, 1'b1, "t3");
    chk("t3_product_msb_clear", 32'(product[DW_2-1]), 32'd0);
    run_op(8'd0, 8'h7F, 0, 1'b0, 1'b0, "t4a");
    run_op(8'hFF, 8'hFF, 1, 1'b1, 1'b1, "t4b");

    // Start while busy must be dropped; next start right after done is accepted.
    start_op(8'd2, 8'd3);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; multiplier = 8'd9; multiplicand = 8'd9;
    @(posedge clk); #1; start = 1'b0;
    wait_done(seen, lat);
    chk("t5_first_done", 32'(seen), 32'd1);
    chk("t5_first_product", 32'(product), 32'd6);
    run_op(8'd4, 8'd4, 16, 1'b0, 1'b0, "t5b");

    // Reset mid-operation aborts with no done pulse.
    start_op(8'd7, 8'd7);
    repeat (4) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    chk("t6_ready", 32'(ready), 32'd1);
    chk("t6_product", 32'(product), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("t6_no_done", 32'(seen), 32'd0);
    run_op(8'd7, 8'd7, 49, 1'b0, 1'b0, "t6b");

    // Random traffic including starts while busy, starts in the done cycle and resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      multiplier   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : DW'($urandom);
      multiplicand = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : DW'($urandom);
      rst = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    repeat (15) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
